// File: rtl/ppm_pkg.sv
// Shared types and frame constants for the PPM byte scheduler and its FIFO.
package ppm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FLAG,
      DATA,
      END,
      GAP
   } ppm_sched_state_t;

   localparam logic PPM_FLAG_BIT  = 1'b0;
   localparam logic PPM_END_BIT   = 1'b1;
   localparam int   PPM_DATA_BITS = 8;

endpackage

// File: rtl/ppm_byte_fifo.sv
// Byte FIFO with registered full/empty/count flags and natural-wrap pointers.
module ppm_byte_fifo
   import ppm_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [PPM_DATA_BITS-1:0]   din,
   output logic [PPM_DATA_BITS-1:0]   dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PPM_DATA_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]            wr_ptr_q;
   logic [AW-1:0]            rd_ptr_q;
   logic [CW-1:0]            count_q;
   logic [CW-1:0]            count_d;
   logic                     full_q;
   logic                     empty_q;
   logic                     do_push;
   logic                     do_pop;

   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   // Flags are registered from the next count so they are glitch-free outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == FULL_CNT);
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/ppm_frame_scheduler.sv
// Serialises queued bytes as {flag 0, 8 data bits MSB-first, end 1} frames
// with an enforced idle gap, feeding ppm_encoder.Din.
module ppm_frame_scheduler
   import ppm_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int BIT_CYCLES = 1,
   parameter int GAP_CYCLES = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [PPM_DATA_BITS-1:0]   in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       ser_out,
   output logic                       frame_active,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [15:0]                frames_sent
);

   localparam int BCW = $clog2(BIT_CYCLES + 1);
   localparam int GCW = $clog2(GAP_CYCLES + 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYCLES - 1);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

   ppm_sched_state_t         state_q;
   logic [BCW-1:0]           bit_cnt_q;
   logic [GCW-1:0]           gap_cnt_q;
   logic [2:0]               bit_idx_q;
   logic [PPM_DATA_BITS-1:0] shift_q;
   logic                     ser_q;
   logic                     active_q;
   logic [15:0]              frames_q;

   logic                     push;
   logic                     pop;
   logic                     bit_last;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [PPM_DATA_BITS-1:0] fifo_dout;

   assign push     = in_valid && !fifo_full;
   assign pop      = (state_q == IDLE) && en && !fifo_empty;
   assign bit_last = (bit_cnt_q == BIT_LAST);

   ppm_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Outputs are registered from the current state, so the line lags the FSM by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         bit_idx_q <= '0;
         ser_q     <= 1'b0;
         active_q  <= 1'b0;
         frames_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               ser_q     <= 1'b0;
               active_q  <= 1'b0;
               bit_cnt_q <= '0;
               if (pop) state_q <= FLAG;
            end
            FLAG: begin
               ser_q    <= PPM_FLAG_BIT;
               active_q <= 1'b1;
               if (bit_last) begin
                  bit_cnt_q <= '0;
                  bit_idx_q <= 3'(PPM_DATA_BITS - 1);
                  state_q   <= DATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + BCW'(1);
               end
            end
            DATA: begin
               ser_q    <= shift_q[PPM_DATA_BITS-1];
               active_q <= 1'b1;
               if (bit_last) begin
                  bit_cnt_q <= '0;
                  if (bit_idx_q == 3'd0) state_q <= END;
                  else                   bit_idx_q <= bit_idx_q - 3'd1;
               end else begin
                  bit_cnt_q <= bit_cnt_q + BCW'(1);
               end
            end
            END: begin
               ser_q    <= PPM_END_BIT;
               active_q <= 1'b1;
               if (bit_last) begin
                  bit_cnt_q <= '0;
                  gap_cnt_q <= '0;
                  frames_q  <= frames_q + 16'd1;
                  state_q   <= GAP;
               end else begin
                  bit_cnt_q <= bit_cnt_q + BCW'(1);
               end
            end
            GAP: begin
               ser_q    <= 1'b0;
               active_q <= 1'b0;
               if (gap_cnt_q == GAP_LAST) state_q <= IDLE;
               else                       gap_cnt_q <= gap_cnt_q + GCW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shift_q <= fifo_dout;
      end else if (state_q == DATA && bit_last) begin
         shift_q <= {shift_q[PPM_DATA_BITS-2:0], 1'b0};
      end
   end

   assign in_ready     = !fifo_full;
   assign ser_out      = ser_q;
   assign frame_active = active_q;
   assign frames_sent  = frames_q;

endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// Randomised bench for ppm_frame_scheduler; expected line traces come from a
// frame-timing model (push time, enable time, previous frame end).
module tb_ppm_frame_scheduler;

   localparam int GAP = 10;
   localparam int CW  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en0, in_valid0, in_ready0, ser0, fa0;
   logic [7:0] in_data0;
   logic [CW-1:0] cnt0;
   logic [15:0]   fs0;
   logic       en1, in_valid1, in_ready1, ser1, fa1;
   logic [7:0] in_data1;
   logic [CW-1:0] cnt1;
   logic [15:0]   fs1;

   ppm_frame_scheduler #(.DEPTH(4), .BIT_CYCLES(1), .GAP_CYCLES(GAP)) u0 (
      .clk(clk), .rst(rst), .en(en0), .in_data(in_data0), .in_valid(in_valid0),
      .in_ready(in_ready0), .ser_out(ser0), .frame_active(fa0),
      .fifo_count(cnt0), .frames_sent(fs0));

   ppm_frame_scheduler #(.DEPTH(4), .BIT_CYCLES(3), .GAP_CYCLES(GAP)) u1 (
      .clk(clk), .rst(rst), .en(en1), .in_data(in_data1), .in_valid(in_valid1),
      .in_ready(in_ready1), .ser_out(ser1), .frame_active(fa1),
      .fifo_count(cnt1), .frames_sent(fs1));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_fs0  = 0;
   int exp_fs1  = 0;

   // Trace index n holds the outputs settled after rising edge n.
   bit tr_ser [2][8192];
   bit tr_fa  [2][8192];

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (cyc < 8192) begin
         tr_ser[0][cyc] = ser0;
         tr_fa[0][cyc]  = fa0;
         tr_ser[1][cyc] = ser1;
         tr_fa[1][cyc]  = fa1;
      end
   end

   // Model: each frame starts the edge after it can be popped; a pop needs the
   // byte queued, en seen high, and GAP+1 cycles since the previous end bit.
   int         m_p[$];
   logic [7:0] m_b[$];
   int         m_s[16];
   int         m_en_edge;

   function automatic void model_reset();
      m_p.delete();
      m_b.delete();
      m_en_edge = 0;
   endfunction

   function automatic void model_build(input int B);
      int prev_end = -1000;
      for (int i = 0; i < m_p.size(); i++) begin
         int pe = m_p[i] + 1;
         if (m_en_edge > pe) pe = m_en_edge;
         if (prev_end + GAP + 1 > pe) pe = prev_end + GAP + 1;
         m_s[i]   = pe + 1;
         prev_end = m_s[i] + 10 * B - 1;
      end
   endfunction

   function automatic logic [127:0] exp_vec(input int B, input int lo, input int len, input bit which);
      logic [127:0] v = '0;
      for (int j = 0; j < len; j++) begin
         int c = lo + j;
         for (int i = 0; i < m_p.size(); i++) begin
            if (c >= m_s[i] && c < m_s[i] + 10 * B) begin
               int k = (c - m_s[i]) / B;
               logic [7:0] b = m_b[i];
               if (which)        v[j] = 1'b1;
               else if (k == 0)  v[j] = 1'b0;
               else if (k == 9)  v[j] = 1'b1;
               else              v[j] = b[8-k];
            end
         end
      end
      return v;
   endfunction

   function automatic logic [127:0] obs_vec(input int inst, input int lo, input int len, input bit which);
      logic [127:0] v = '0;
      for (int j = 0; j < len; j++) begin
         if (lo + j >= 0 && lo + j < 8192)
            v[j] = which ? tr_fa[inst][lo+j] : tr_ser[inst][lo+j];
      end
      return v;
   endfunction

   function automatic int exp_count(input int t);
      int n = 0;
      for (int i = 0; i < m_p.size(); i++) begin
         if (m_p[i] <= t) n++;
         if (m_s[i] - 1 <= t) n--;
      end
      return n;
   endfunction

   // Drives one byte (called at a negedge); returns the edge that accepted it.
   task automatic push(input int inst, input logic [7:0] b, output int p);
      int g = 0;
      if (inst == 0) begin in_valid0 = 1'b1; in_data0 = b; end
      else           begin in_valid1 = 1'b1; in_data1 = b; end
      while (((inst == 0) ? in_ready0 : in_ready1) !== 1'b1 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: in_ready stayed %b for 200 cycles, required 1",
                  (inst == 0) ? in_ready0 : in_ready1);
         p = -1;
      end else begin
         @(negedge clk);
         p = cyc;
         m_p.push_back(p);
         m_b.push_back(b);
      end
      if (inst == 0) in_valid0 = 1'b0;
      else           in_valid1 = 1'b0;
   endtask

   task automatic test_reset();
      logic [127:0] o;
      int lo;
      rst = 1'b0;
      en0 = 1'b1; en1 = 1'b1;
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      in_data0 = '0; in_data1 = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (ser0 !== 1'b0)      begin n_fail++; $display("FAIL reset_ser: got %b want 0", ser0); end
      n_checks++; if (fa0 !== 1'b0)       begin n_fail++; $display("FAIL reset_active: got %b want 0", fa0); end
      n_checks++; if (cnt0 !== 3'd0)      begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt0); end
      n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready0); end
      n_checks++; if (fs0 !== 16'd0)      begin n_fail++; $display("FAIL reset_frames: got %0d want 0", fs0); end
      rst = 1'b1;
      lo = cyc + 1;
      repeat (25) @(negedge clk);
      o = obs_vec(0, lo, 24, 1'b1) | obs_vec(0, lo, 24, 1'b0);
      n_checks++; if (o !== '0) begin n_fail++; $display("FAIL empty_idle: line/active trace %h want 0", o); end
   endtask

   task automatic test_single_frames();
      logic [7:0] bytes [8];
      logic [127:0] o, e;
      int p;
      bytes[0] = 8'h00; bytes[1] = 8'h20; bytes[2] = 8'h22; bytes[3] = 8'hFF; bytes[4] = 8'hC8;
      for (int i = 5; i < 8; i++) bytes[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         model_reset();
         push(0, bytes[i], p);
         repeat (10 + GAP + 6) @(negedge clk);
         model_build(1);
         exp_fs0++;
         o = obs_vec(0, p, 26, 1'b0);
         e = exp_vec(1, p, 26, 1'b0);
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_ser byte %h: got %h want %h", bytes[i], o, e); end
         o = obs_vec(0, p, 26, 1'b1);
         e = exp_vec(1, p, 26, 1'b1);
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_active byte %h: got %h want %h", bytes[i], o, e); end
         n_checks++; if (fs0 !== 16'(exp_fs0)) begin n_fail++; $display("FAIL single_frames: got %0d want %0d", fs0, exp_fs0); end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] o, e;
      int p [3];
      int rises, d1, d2, last;
      for (int r = 0; r < 2; r++) begin
         model_reset();
         for (int i = 0; i < 3; i++) push(0, (r == 0) ? 8'h00 : 8'($urandom), p[i]);
         model_build(1);
         n_checks++;
         if (cnt0 !== 3'(exp_count(cyc))) begin
            n_fail++; $display("FAIL b2b_count: got %0d want %0d", cnt0, exp_count(cyc));
         end
         repeat (100) @(negedge clk);
         exp_fs0 += 3;
         o = obs_vec(0, p[0], 100, 1'b0);
         e = exp_vec(1, p[0], 100, 1'b0);
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_ser round %0d: got %h want %h", r, o, e); end
         o = obs_vec(0, p[0], 100, 1'b1);
         e = exp_vec(1, p[0], 100, 1'b1);
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_active round %0d: got %h want %h", r, o, e); end
         rises = 0; d1 = 0; d2 = 0; last = 0;
         for (int c = p[0]; c < p[0] + 100; c++) begin
            if (tr_fa[0][c] && !tr_fa[0][c-1]) begin
               if (rises == 1) d1 = c - last;
               if (rises == 2) d2 = c - last;
               last = c;
               rises++;
            end
         end
         n_checks++;
         if (rises !== 3 || d1 !== 10 + GAP + 1 || d2 !== 10 + GAP + 1) begin
            n_fail++; $display("FAIL b2b_period: frames %0d spacing %0d/%0d want 3 frames spacing %0d", rises, d1, d2, 10 + GAP + 1);
         end
         n_checks++; if (fs0 !== 16'(exp_fs0)) begin n_fail++; $display("FAIL b2b_frames: got %0d want %0d", fs0, exp_fs0); end
      end
   endtask

   task automatic test_full_fifo();
      logic [127:0] o, e;
      int p, p_first, g, lo;
      logic [7:0] b5;
      model_reset();
      en0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(0, 8'($urandom), p);
         if (i == 0) p_first = p;
         if (i == 2) begin
            n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL full_ready_early: got %b want 1", in_ready0); end
         end
      end
      n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", in_ready0); end
      n_checks++; if (cnt0 !== 3'd4)      begin n_fail++; $display("FAIL full_count: got %0d want 4", cnt0); end
      b5 = 8'($urandom);
      in_valid0 = 1'b1;
      in_data0  = b5;
      repeat (8) @(negedge clk);
      o = obs_vec(0, p_first, cyc - p_first + 1, 1'b1);
      n_checks++; if (o !== '0) begin n_fail++; $display("FAIL full_no_frame: active trace %h want 0", o); end
      n_checks++; if (cnt0 !== 3'd4 || in_ready0 !== 1'b0) begin
         n_fail++; $display("FAIL full_hold: count %0d ready %b want 4 0", cnt0, in_ready0);
      end
      en0 = 1'b1;
      m_en_edge = cyc + 1;
      g = 0;
      while (in_ready0 !== 1'b1 && g < 100) begin @(negedge clk); g++; end
      @(negedge clk);
      p = cyc;
      in_valid0 = 1'b0;
      m_p.push_back(p);
      m_b.push_back(b5);
      n_checks++; if (p !== m_en_edge + 1) begin n_fail++; $display("FAIL full_fifth_accept: edge %0d want %0d", p, m_en_edge + 1); end
      model_build(1);
      repeat (125) @(negedge clk);
      exp_fs0 += 5;
      lo = m_en_edge - 2;
      o = obs_vec(0, lo, 125, 1'b0);
      e = exp_vec(1, lo, 125, 1'b0);
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_drain_ser: got %h want %h", o, e); end
      o = obs_vec(0, lo, 125, 1'b1);
      e = exp_vec(1, lo, 125, 1'b1);
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_drain_active: got %h want %h", o, e); end
      n_checks++; if (fs0 !== 16'(exp_fs0)) begin n_fail++; $display("FAIL full_frames: got %0d want %0d", fs0, exp_fs0); end
   endtask

   task automatic test_reset_midframe();
      logic [127:0] o, e;
      logic [7:0] b0;
      int p [3];
      int g, lo, s0;
      model_reset();
      b0 = 8'($urandom) | 8'h10;
      push(0, b0, p[0]);
      push(0, 8'($urandom), p[1]);
      push(0, 8'($urandom), p[2]);
      model_build(1);
      s0 = m_s[0];
      g = 0;
      while (cyc < s0 + 4 && g < 100) begin @(negedge clk); g++; end
      n_checks++; if (ser0 !== b0[4]) begin n_fail++; $display("FAIL mid_data_bit4: got %b want %b", ser0, b0[4]); end
      rst = 1'b0;
      #1;
      n_checks++; if (ser0 !== 1'b0)      begin n_fail++; $display("FAIL async_ser: got %b want 0", ser0); end
      n_checks++; if (fa0 !== 1'b0)       begin n_fail++; $display("FAIL async_active: got %b want 0", fa0); end
      n_checks++; if (cnt0 !== 3'd0)      begin n_fail++; $display("FAIL async_count: got %0d want 0", cnt0); end
      n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL async_ready: got %b want 1", in_ready0); end
      n_checks++; if (fs0 !== 16'd0)      begin n_fail++; $display("FAIL async_frames: got %0d want 0", fs0); end
      @(negedge clk);
      rst = 1'b1;
      exp_fs0 = 0;
      exp_fs1 = 0;
      lo = cyc + 1;
      repeat (40) @(negedge clk);
      o = obs_vec(0, lo, 39, 1'b1) | obs_vec(0, lo, 39, 1'b0);
      n_checks++; if (o !== '0) begin n_fail++; $display("FAIL post_reset_quiet: trace %h want 0", o); end
      model_reset();
      push(0, 8'($urandom), p[0]);
      repeat (10 + GAP + 6) @(negedge clk);
      model_build(1);
      exp_fs0++;
      o = obs_vec(0, p[0], 26, 1'b0);
      e = exp_vec(1, p[0], 26, 1'b0);
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL post_reset_frame: got %h want %h", o, e); end
      n_checks++; if (fs0 !== 16'(exp_fs0)) begin n_fail++; $display("FAIL post_reset_frames: got %0d want %0d", fs0, exp_fs0); end
   endtask

   task automatic test_bit_cycles();
      logic [127:0] o, e;
      logic [9:0] pat;
      int p;
      for (int r = 0; r < 2; r++) begin
         model_reset();
         push(1, (r == 0) ? 8'hA5 : 8'($urandom), p);
         repeat (50) @(negedge clk);
         model_build(3);
         exp_fs1++;
         o = obs_vec(1, p, 48, 1'b0);
         e = exp_vec(3, p, 48, 1'b0);
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL bc3_ser round %0d: got %h want %h", r, o, e); end
         o = obs_vec(1, p, 48, 1'b1);
         e = exp_vec(3, p, 48, 1'b1);
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL bc3_active round %0d: got %h want %h", r, o, e); end
         if (r == 0) begin
            pat = '0;
            for (int k = 0; k < 10; k++) pat = {pat[8:0], tr_ser[1][p+2+3*k]};
            n_checks++; if (pat !== 10'b0101001011) begin n_fail++; $display("FAIL bc3_a5_pattern: got %b want 0101001011", pat); end
         end
         n_checks++; if (fs1 !== 16'(exp_fs1)) begin n_fail++; $display("FAIL bc3_frames: got %0d want %0d", fs1, exp_fs1); end
      end
   endtask

   initial begin
      test_reset();
      test_single_frames();
      test_back_to_back();
      test_full_fifo();
      test_reset_midframe();
      test_bit_cycles();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
